// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Decodes the RV32/RV64 immediate formats (I, S, B, J, U, CSR-zimm and
//   shift-amount) and registers the result into the ID->EX boundary. A
//   2-entry skid buffer with a valid/ready handshake sits between the two
//   stages and supports stall and flush.
// Parameters
//   XLEN   width of ImmExt, 32 or 64
//   TAG_W  width of the sideband tag (PC) carried with each immediate
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_ready comes only from registers
//   Instr, ImmSrc        instruction bits [31:7] and the format select
//   in_tag               sideband tag, passed through unchanged
//   flush                synchronous kill of every buffered entry
//   out_valid/out_ready  output handshake
//   ImmExt, out_tag      extended immediate and its tag
//   illegal              ImmSrc held the reserved encoding 3'b111
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:7]      Instr,
   input  logic [2:0]       ImmSrc,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  ImmExt,
   output logic [TAG_W-1:0] out_tag,
   output logic             illegal
);

   logic [31:0]      imm32;
   logic             signExt;
   logic             decIll;
   logic [XLEN-1:0]  decImm;

   logic             mainValid;
   logic [XLEN-1:0]  mainImm;
   logic [TAG_W-1:0] mainTag;
   logic             mainIll;

   logic             skidValid;
   logic [XLEN-1:0]  skidImm;
   logic [TAG_W-1:0] skidTag;
   logic             skidIll;

   logic             push;
   logic             pop;

   // Every format is first assembled as a 32-bit value; the signed formats
   // are then sign-extended to XLEN and the unsigned ones zero-extended.
   always_comb begin
      imm32   = '0;
      signExt = 1'b1;
      decIll  = 1'b0;
      case (ImmSrc)
         3'b000: imm32 = {{20{Instr[31]}}, Instr[31:20]};
         3'b001: imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
         3'b010: imm32 = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25],
                          Instr[11:8], 1'b0};
         3'b011: imm32 = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20],
                          Instr[30:21], 1'b0};
         3'b100: imm32 = {Instr[31:12], 12'b0};
         3'b101: begin
            imm32   = {27'b0, Instr[19:15]};
            signExt = 1'b0;
         end
         3'b110: begin
            imm32   = (XLEN == 64) ? {26'b0, Instr[25:20]} : {27'b0, Instr[24:20]};
            signExt = 1'b0;
         end
         default: decIll = 1'b1;
      endcase
      decImm = signExt ? XLEN'(signed'(imm32)) : XLEN'(imm32);
   end

   assign in_ready  = !skidValid;
   assign push      = in_valid && !skidValid;
   assign pop       = mainValid && out_ready;

   assign out_valid = mainValid;
   assign ImmExt    = mainImm;
   assign out_tag   = mainTag;
   assign illegal   = mainIll;

   // Data registers load only on an accepted push, so undefined Instr or
   // ImmSrc while in_valid is low never reaches the outputs. When the skid
   // entry is full in_ready is low, so its refill into main cannot collide
   // with a push in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mainValid <= 1'b0;
         mainImm   <= '0;
         mainTag   <= '0;
         mainIll   <= 1'b0;
         skidValid <= 1'b0;
         skidImm   <= '0;
         skidTag   <= '0;
         skidIll   <= 1'b0;
      end else if (flush) begin
         mainValid <= 1'b0;
         skidValid <= 1'b0;
      end else if (skidValid && pop) begin
         mainImm   <= skidImm;
         mainTag   <= skidTag;
         mainIll   <= skidIll;
         skidValid <= 1'b0;
      end else if (push && (!mainValid || pop)) begin
         mainValid <= 1'b1;
         mainImm   <= decImm;
         mainTag   <= in_tag;
         mainIll   <= decIll;
      end else if (push) begin
         skidValid <= 1'b1;
         skidImm   <= decImm;
         skidTag   <= in_tag;
         skidIll   <= decIll;
      end else if (pop) begin
         mainValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] instrW;
   logic [2:0]  ImmSrc;
   logic [31:0] in_tag;
   logic        flush;
   logic        out_ready;

   logic        inReady32, outValid32, illegal32;
   logic [31:0] immExt32, outTag32;
   logic        inReady64, outValid64, illegal64;
   logic [63:0] immExt64;
   logic [31:0] outTag64;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [63:0] e32;
      logic [63:0] e64;
      logic [31:0] tag;
      logic        ill;
   } entry_t;

   entry_t q[$];

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady32),
      .Instr(instrW[31:7]), .ImmSrc(ImmSrc), .in_tag(in_tag), .flush(flush),
      .out_valid(outValid32), .out_ready(out_ready), .ImmExt(immExt32),
      .out_tag(outTag32), .illegal(illegal32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady64),
      .Instr(instrW[31:7]), .ImmSrc(ImmSrc), .in_tag(in_tag), .flush(flush),
      .out_valid(outValid64), .out_ready(out_ready), .ImmExt(immExt64),
      .out_tag(outTag64), .illegal(illegal64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference immediate: field value as an integer, minus 2^width when the
   // sign bit is set, then truncated to the datapath width.
   function automatic logic [63:0] refImm(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen);
      longint v;
      v = 0;
      case (src)
         3'd0: v = longint'(ins[31:20]);
         3'd1: v = longint'({ins[31:25], ins[11:7]});
         3'd2: v = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
         3'd3: v = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
         3'd4: v = longint'(ins[31:12]) * 4096;
         3'd5: v = longint'(ins[19:15]);
         3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
         default: v = 0;
      endcase
      if (ins[31]) begin
         case (src)
            3'd0, 3'd1: v = v - 4096;
            3'd2:       v = v - 8192;
            3'd3:       v = v - 2097152;
            3'd4:       v = v - 64'sh1_0000_0000;
            default:    v = v;
         endcase
      end
      if (xlen == 32) return 64'(v) & 64'h0000_0000_FFFF_FFFF;
      return 64'(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compares both DUTs against the model queue; runs at the negedge.
   task automatic compare();
      logic expRdy, expVal;
      expRdy = (q.size() < 2);
      expVal = (q.size() > 0);
      chk("in_ready32",  64'(inReady32),  64'(expRdy));
      chk("in_ready64",  64'(inReady64),  64'(expRdy));
      chk("out_valid32", 64'(outValid32), 64'(expVal));
      chk("out_valid64", 64'(outValid64), 64'(expVal));
      if (expVal) begin
         chk("ImmExt32",  64'(immExt32),  q[0].e32);
         chk("ImmExt64",  immExt64,       q[0].e64);
         chk("out_tag32", 64'(outTag32),  64'(q[0].tag));
         chk("out_tag64", 64'(outTag64),  64'(q[0].tag));
         chk("illegal32", 64'(illegal32), 64'(q[0].ill));
         chk("illegal64", 64'(illegal64), 64'(q[0].ill));
      end
   endtask

   // Drives one cycle of inputs, advances the FIFO model, waits for the
   // next negedge and compares.
   task automatic step(input logic iv, input logic [31:0] ins, input logic [2:0] src,
                       input logic [31:0] tag, input logic ordy, input logic fl);
      entry_t e;
      logic   acc, pp;
      in_valid  = iv;
      instrW    = ins;
      ImmSrc    = src;
      in_tag    = tag;
      out_ready = ordy;
      flush     = fl;
      acc = iv && (q.size() < 2);
      pp  = (q.size() > 0) && ordy;
      if (fl) begin
         q.delete();
      end else begin
         if (pp) void'(q.pop_front());
         if (acc) begin
            e.e32 = refImm(ins, src, 32);
            e.e64 = refImm(ins, src, 64);
            e.tag = tag;
            e.ill = (src == 3'd7);
            q.push_back(e);
         end
      end
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
   endtask

   // Single transfer from an empty pipe, pinned to hand-computed literals.
   task automatic directed(input string nm, input logic [31:0] ins, input logic [2:0] src,
                           input logic [31:0] tag, input logic [63:0] exp32,
                           input logic [63:0] exp64, input logic expIll);
      idle(2);
      step(1'b1, ins, src, tag, 1'b1, 1'b0);
      chk({nm, "_lit_valid"}, 64'(outValid32 & outValid64), 64'd1);
      chk({nm, "_lit_imm32"}, 64'(immExt32), exp32);
      chk({nm, "_lit_imm64"}, immExt64, exp64);
      chk({nm, "_lit_tag"},   64'(outTag32), 64'(tag));
      chk({nm, "_lit_ill"},   64'(illegal64), 64'(expIll));
   endtask

   task automatic resetChecks(input string nm);
      chk({nm, "_valid32"}, 64'(outValid32), 64'd0);
      chk({nm, "_valid64"}, 64'(outValid64), 64'd0);
      chk({nm, "_imm32"},   64'(immExt32),   64'd0);
      chk({nm, "_imm64"},   immExt64,        64'd0);
      chk({nm, "_tag32"},   64'(outTag32),   64'd0);
      chk({nm, "_tag64"},   64'(outTag64),   64'd0);
      chk({nm, "_ill"},     64'(illegal32 | illegal64), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      instrW    = '0;
      ImmSrc    = '0;
      in_tag    = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      resetChecks("reset");
      rst_n = 1'b1;
      @(negedge clk);
      compare();

      directed("T1_I",   32'hFFF00093, 3'd0, 32'h100, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      directed("T2_B",   32'hFE000EE3, 3'd2, 32'h104, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      directed("T2_J",   32'hFF9FF06F, 3'd3, 32'h108, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
      directed("T2_U",   32'h12345037, 3'd4, 32'h10C, 64'h1234_5000, 64'h0000_0000_1234_5000, 1'b0);
      directed("T2_Z",   32'h000F8073, 3'd5, 32'h110, 64'h0000_001F, 64'h0000_0000_0000_001F, 1'b0);
      directed("T2_RES", 32'hFFFFFFFF, 3'd7, 32'h114, 64'h0,         64'h0,                   1'b1);
      directed("T3_U",   32'h80000037, 3'd4, 32'h118, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
      directed("T3_SH",  32'h03F00013, 3'd6, 32'h11C, 64'h0000_001F, 64'h0000_0000_0000_003F, 1'b0);
      directed("S_neg",  32'hFE000FA3, 3'd1, 32'h120, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      idle(2);

      // Backpressure: tags 1..6, consumer stalls on cycles 2-4.
      begin
         int nextTag = 1;
         for (int c = 1; c <= 12; c++) begin
            logic ordy;
            logic iv;
            ordy = !(c >= 2 && c <= 4);
            iv   = (nextTag <= 6);
            if (iv && q.size() < 2) begin
               step(1'b1, $urandom(), 3'($urandom_range(6, 0)), 32'(nextTag), ordy, 1'b0);
               nextTag++;
            end else begin
               step(iv, $urandom(), 3'($urandom_range(6, 0)), 32'(nextTag), ordy, 1'b0);
            end
            if (c == 3) chk("T4_in_ready_low", 64'(inReady32), 64'd0);
         end
         chk("T4_all_sent", 64'(nextTag), 64'd7);
      end
      idle(2);

      // Flush with main and skid full and a live input in the flush cycle.
      step(1'b1, 32'h00100093, 3'd0, 32'hA1, 1'b0, 1'b0);
      step(1'b1, 32'h00200093, 3'd0, 32'hA2, 1'b0, 1'b0);
      step(1'b1, 32'h00300093, 3'd0, 32'hDEAD, 1'b0, 1'b1);
      chk("T5_valid_after_flush", 64'(outValid32), 64'd0);
      chk("T5_ready_after_flush", 64'(inReady64), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
         chk("T5_no_dropped_input", 64'(outValid32 && outTag32 == 32'hDEAD), 64'd0);
      end

      // Randomised traffic with occasional flush and a mid-stream async reset.
      for (int c = 0; c < 3000; c++) begin
         step(1'($urandom_range(3, 0) != 0), $urandom(), 3'($urandom_range(7, 0)),
              $urandom(), 1'($urandom_range(2, 0) != 0), 1'($urandom_range(39, 0) == 0));
         if (c == 1500) begin
            step(1'b1, 32'hABCDE037, 3'd4, 32'h55, 1'b0, 1'b0);
            step(1'b1, 32'h12300093, 3'd0, 32'h56, 1'b0, 1'b0);
            #2 rst_n = 1'b0;
            #1 resetChecks("T6_async");
            q.delete();
            in_valid = 1'b0;
            flush    = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            step(1'b1, 32'hFFF00093, 3'd0, 32'h77, 1'b1, 1'b0);
            chk("T6_first_after_reset", 64'(outTag32), 64'h77);
         end
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
